// File: rtl/booth_mac_accum_if.sv
// rtl/booth_mac_accum_if.sv - product input / frame-sum output bundle for booth_mac_accum
interface booth_mac_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
);
    logic                     prod_vld;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_rdy;
    logic        [CNT_W-1:0]  frame_len;
    logic                     clr;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     acc_vld;
    logic                     acc_rdy;
    logic                     sat_flag;
    logic                     drop_err;
    logic                     busy;

    modport slave (
        input  prod_vld, prod, frame_len, clr, acc_rdy,
        output prod_rdy, acc_out, acc_vld, sat_flag, drop_err, busy
    );

    modport master (
        output prod_vld, prod, frame_len, clr, acc_rdy,
        input  prod_rdy, acc_out, acc_vld, sat_flag, drop_err, busy
    );
endinterface

// File: rtl/booth_mac_accum.sv
// rtl/booth_mac_accum.sv - saturating frame accumulator for signed Booth products
module booth_mac_accum #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rstn,
    booth_mac_accum_if.slave    bus
);
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_len;
    logic                    r_acc_vld;
    logic                    r_busy;
    logic                    r_sat;
    logic                    r_drop;

    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic                    w_ovf_hi;
    logic                    w_ovf_lo;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0]        w_len_eff;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_last;
    logic                    w_prod_rdy;
    logic                    w_start;

    assign w_prod_ext = ACC_W'(bus.prod);
    assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_prod_ext);
    // One extra bit: top two bits disagreeing means the ACC_W result overflowed
    assign w_ovf_hi   = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
    assign w_ovf_lo   =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
    assign w_acc_next = w_ovf_hi ? ACC_MAX : (w_ovf_lo ? ACC_MIN : w_sum[ACC_W-1:0]);

    assign w_len_eff  = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == r_len);

    assign w_prod_rdy = (r_state != HOLD) | bus.acc_rdy;
    // A product in HOLD that coincides with the output handshake opens the next frame
    assign w_start    = bus.prod_vld & ((r_state == IDLE) | ((r_state == HOLD) & bus.acc_rdy));

    always_ff @(posedge clk) begin
        if (!rstn || bus.clr) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_acc_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_sat     <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            if (bus.prod_vld && !w_prod_rdy) begin
                r_drop <= 1'b1;
            end
            if (w_start) begin
                r_acc  <= w_prod_ext;
                r_cnt  <= CNT_W'(1);
                r_len  <= w_len_eff;
                r_sat  <= 1'b0;
                r_busy <= 1'b1;
                if (w_len_eff == CNT_W'(1)) begin
                    r_state   <= HOLD;
                    r_acc_vld <= 1'b1;
                end else begin
                    r_state   <= ACCUM;
                    r_acc_vld <= 1'b0;
                end
            end else begin
                case (r_state)
                    ACCUM: begin
                        if (bus.prod_vld) begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_inc;
                            if (w_ovf_hi || w_ovf_lo) begin
                                r_sat <= 1'b1;
                            end
                            if (w_last) begin
                                r_state   <= HOLD;
                                r_acc_vld <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (bus.acc_rdy) begin
                            r_state   <= IDLE;
                            r_acc_vld <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.prod_rdy = w_prod_rdy;
    assign bus.acc_out  = r_acc;
    assign bus.acc_vld  = r_acc_vld;
    assign bus.sat_flag = r_sat;
    assign bus.drop_err = r_drop;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_booth_mac_accum.sv
// tb/tb_booth_mac_accum.sv - directed-vector bench for booth_mac_accum
module tb_booth_mac_accum;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    booth_mac_accum_if #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) bus ();
    booth_mac_accum_if #(.PROD_W(8), .ACC_W(12), .CNT_W(8)) bus12 ();

    booth_mac_accum #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    booth_mac_accum #(.PROD_W(8), .ACC_W(12), .CNT_W(8)) u_dut12 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus12)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] p);
        bus.prod_vld = 1'b1;
        bus.prod     = p;
        step();
        bus.prod_vld = 1'b0;
    endtask

    task automatic send12(input logic signed [7:0] p);
        bus12.prod_vld = 1'b1;
        bus12.prod     = p;
        step();
        bus12.prod_vld = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".acc_out"},  bus.acc_out,  0);
        chk({tag, ".acc_vld"},  bus.acc_vld,  0);
        chk({tag, ".sat_flag"}, bus.sat_flag, 0);
        chk({tag, ".drop_err"}, bus.drop_err, 0);
        chk({tag, ".prod_rdy"}, bus.prod_rdy, 1);
        chk({tag, ".busy"},     bus.busy,     0);
    endtask

    initial begin
        bus.prod_vld = 1'b0;  bus.prod = '0;  bus.frame_len = '0;  bus.clr = 1'b0;  bus.acc_rdy = 1'b1;
        bus12.prod_vld = 1'b0; bus12.prod = '0; bus12.frame_len = '0; bus12.clr = 1'b0; bus12.acc_rdy = 1'b1;
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        chk_reset_state("rst");

        // frame of 4: 6 - 9 + 64 - 1 = 60
        bus.frame_len = 8'd4;
        send(8'sd6);
        chk("f4.busy", bus.busy, 1);
        send(-8'sd9);
        chk("f4.run", bus.acc_out, -3);
        chk("f4.vld_early", bus.acc_vld, 0);
        send(8'sd64);
        send(-8'sd1);
        chk("f4.vld", bus.acc_vld, 1);
        chk("f4.sum", bus.acc_out, 60);
        chk("f4.sat", bus.sat_flag, 0);
        step();
        chk("f4.idle_vld", bus.acc_vld, 0);
        chk("f4.idle_busy", bus.busy, 0);
        chk("f4.held", bus.acc_out, 60);

        // length 0 behaves as length 1
        bus.frame_len = 8'd0;
        send(-8'sd8);
        chk("len0.vld", bus.acc_vld, 1);
        chk("len0.sum", bus.acc_out, -8);
        step();
        chk("len0.idle", bus.busy, 0);

        // 12-bit accumulator saturation, both directions
        bus12.frame_len = 8'd40;
        for (int i = 0; i < 40; i++) send12(8'sd64);
        chk("sat+.vld", bus12.acc_vld, 1);
        chk("sat+.sum", bus12.acc_out, 2047);
        chk("sat+.flag", bus12.sat_flag, 1);
        step();
        send12(-8'sd64);
        chk("sat-.flag_clr", bus12.sat_flag, 0);
        for (int i = 1; i < 40; i++) send12(-8'sd64);
        chk("sat-.vld", bus12.acc_vld, 1);
        chk("sat-.sum", bus12.acc_out, -2048);
        chk("sat-.flag", bus12.sat_flag, 1);
        step();

        // backpressure: product while HOLD and acc_rdy=0 is dropped
        bus.frame_len = 8'd2;
        bus.acc_rdy = 1'b0;
        send(8'sd10);
        send(8'sd20);
        chk("bp.vld", bus.acc_vld, 1);
        chk("bp.sum", bus.acc_out, 30);
        chk("bp.rdy", bus.prod_rdy, 0);
        send(8'sd7);
        chk("bp.drop", bus.drop_err, 1);
        chk("bp.held", bus.acc_out, 30);
        chk("bp.still_vld", bus.acc_vld, 1);
        bus.acc_rdy = 1'b1;
        #1;
        chk("bp.rdy_up", bus.prod_rdy, 1);
        send(8'sd5);
        chk("bp.new_acc", bus.acc_out, 5);
        chk("bp.new_busy", bus.busy, 1);
        chk("bp.new_vld", bus.acc_vld, 0);
        chk("bp.drop_sticky", bus.drop_err, 1);
        send(8'sd1);
        chk("bp.sum2", bus.acc_out, 6);
        step();

        // clr mid-frame overrides a coincident product
        bus.frame_len = 8'd3;
        send(8'sd3);
        send(8'sd4);
        bus.clr = 1'b1;
        send(8'sd100);
        bus.clr = 1'b0;
        chk_reset_state("clr");
        bus.acc_rdy = 1'b0;
        send(8'sd2);
        send(-8'sd5);
        send(8'sd11);
        chk("clr.vld", bus.acc_vld, 1);
        chk("clr.sum", bus.acc_out, 8);

        // reset while presenting a result
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk_reset_state("rst_hold");

        // every 4x4 signed product, one-product frames back to back
        bus.acc_rdy = 1'b1;
        bus.frame_len = 8'd1;
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                int p;
                p = a * b;
                send(8'(p));
                chk("mul.vld", bus.acc_vld, 1);
                chk($sformatf("mul.%0dx%0d", a, b), bus.acc_out, p);
            end
        end
        step();
        chk("end.idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
